emd_extrema_finder: RTL and testbench

- Streaming producer of extremum triples for the EMD slope/interpolation datapath.
- Scans a signed 20-bit sample stream and detects local maxima or local minima.
- Keeps the three most recent extrema as (value, position) pairs: M1/P1 oldest, M3/P3 newest.
- Presents them with a valid/ready handshake to the slope unit, which computes 16*(M2-M1)/(P2-P1).

---
 rtl/emd_extrema_finder.sv | 149 ++++++++++++++
 tb/tb_emd_extrema_finder.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/emd_extrema_finder.sv
// emd_extrema_finder
//   Streaming local-extremum detector for the EMD envelope datapath. Scans a
//   signed sample stream and keeps the three most recent extrema of one type
//   (maxima when EXT_TYPE=1, minima when EXT_TYPE=0) as value/position pairs,
//   M1/P1 oldest .. M3/P3 newest. These are handed to the slope unit over a
//   valid/ready handshake.
//
//   Ports:
//     clk, rst          rising-edge clock, synchronous active-high reset
//     sample_in         signed W-bit sample
//     sample_valid      sample_in is valid
//     frame_start       accepted sample is index 0 of a new frame
//     sample_ready      block can take a sample this cycle
//     M1..M3            extremum values, oldest to newest (signed)
//     P1..P3            positions of M1..M3 (unsigned, wrap mod 2^W)
//     out_valid         M/P triple valid
//     out_ready         downstream takes the triple
//
//   Optional build macro: EMD_EDGE_PAD_EN -- when defined, the first sample
//   after reset or frame_start is pushed as a boundary extremum at position 0.

module emd_extrema_finder #(
    parameter int EXT_TYPE = 1,
    parameter int W        = 20
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] sample_in,
    input  logic         sample_valid,
    input  logic         frame_start,
    output logic         sample_ready,
    output logic [W-1:0] M1,
    output logic [W-1:0] M2,
    output logic [W-1:0] M3,
    output logic [W-1:0] P1,
    output logic [W-1:0] P2,
    output logic [W-1:0] P3,
    output logic         out_valid,
    input  logic         out_ready
);

    typedef enum logic [1:0] {FILL0, FILL1, RUN} state_t;

    state_t              state, state_nx;
    logic signed [W-1:0] x0, x1, x2;
    logic [W-1:0]        p1, pos, pos_cur;
    logic [1:0]          cnt, cnt_base, cnt_nx;
    logic                accept, is_ext, push;
    logic [W-1:0]        push_val, push_pos;

    assign x0           = $signed(sample_in);
    // Stall input only while a triple is pending and not being taken, so the
    // M/P registers never move under a held out_valid.
    assign sample_ready = !(out_valid && !out_ready);
    assign accept       = sample_valid && sample_ready;
    // frame_start forces the accepted sample to index 0.
    assign pos_cur      = frame_start ? '0 : pos;

    // Candidate is x1; strict on the left and non-strict on the right so a
    // plateau reports its first sample.
    always_comb begin
        is_ext = 1'b0;
        if (EXT_TYPE != 0)
            is_ext = (x2 < x1) && (x1 >= x0);
        else
            is_ext = (x2 > x1) && (x1 <= x0);
    end

    always_comb begin
        state_nx = state;
        push     = 1'b0;
        push_val = x1;
        push_pos = p1;
        if (accept) begin
            if (frame_start) begin
                state_nx = FILL1;
            end else begin
                case (state)
                    FILL0:   state_nx = FILL1;
                    FILL1:   state_nx = RUN;
                    RUN: begin
                        state_nx = RUN;
                        push     = is_ext;
                    end
                    default: state_nx = FILL0;
                endcase
            end
`ifdef EMD_EDGE_PAD_EN
            // Endpoint padding: first sample of the stream/frame is a boundary extremum.
            if (frame_start || state == FILL0) begin
                push     = 1'b1;
                push_val = sample_in;
                push_pos = pos_cur;
            end
`endif
        end
    end

    // frame_start restarts the extremum count before this sample's push.
    always_comb begin
        cnt_base = (accept && frame_start) ? 2'd0 : cnt;
        cnt_nx   = (push && cnt_base != 2'd3) ? cnt_base + 2'd1 : cnt_base;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= FILL0;
        else     state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x1        <= '0;
            x2        <= '0;
            p1        <= '0;
            pos       <= '0;
            cnt       <= '0;
            M1        <= '0;
            M2        <= '0;
            M3        <= '0;
            P1        <= '0;
            P2        <= '0;
            P3        <= '0;
            out_valid <= 1'b0;
        end else begin
            if (accept) begin
                x1  <= x0;
                x2  <= frame_start ? '0 : x1;
                p1  <= pos_cur;
                pos <= pos_cur + 1'b1;
                cnt <= cnt_nx;
            end
            if (push) begin
                M1 <= M2;
                M2 <= M3;
                M3 <= push_val;
                P1 <= P2;
                P2 <= P3;
                P3 <= push_pos;
            end
            if (accept && frame_start)
                out_valid <= 1'b0;
            else if (push && cnt_nx == 2'd3)
                out_valid <= 1'b1;
            else if (out_ready)
                out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_emd_extrema_finder.sv
// Bench for emd_extrema_finder: one min-mode and one max-mode instance share
// the input stream. A reference model predicts each triple at stimulus time
// and queues it; a negedge monitor pops and compares on every consumed output.
module tb_emd_extrema_finder;
    localparam int W = 20;

    typedef struct {
        logic [W-1:0] m1, m2, m3, p1, p2, p3;
    } trip_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] sin;
    logic         tv, fsin, ordy;
    logic         sv;
    logic [W-1:0] m1[2], m2[2], m3[2], p1[2], p2[2], p3[2];
    logic         ov[2], rdy[2];

    int total, bad;

    trip_t        q0[$], q1[$];
    int           hv[$];
    logic [W-1:0] hp[$];
    logic [W-1:0] mpos;
    logic [W-1:0] em[2][3], ep[2][3];
    int           ec[2];
    int           seq[$];

    always #5 clk = ~clk;

    // Present a sample only when both instances can take it so they stay in step.
    assign sv = tv && rdy[0] && rdy[1];

    emd_extrema_finder #(.EXT_TYPE(0), .W(W)) u_min (
        .clk(clk), .rst(rst), .sample_in(sin), .sample_valid(sv),
        .frame_start(fsin), .sample_ready(rdy[0]),
        .M1(m1[0]), .M2(m2[0]), .M3(m3[0]), .P1(p1[0]), .P2(p2[0]), .P3(p3[0]),
        .out_valid(ov[0]), .out_ready(ordy));

    emd_extrema_finder #(.EXT_TYPE(1), .W(W)) u_max (
        .clk(clk), .rst(rst), .sample_in(sin), .sample_valid(sv),
        .frame_start(fsin), .sample_ready(rdy[1]),
        .M1(m1[1]), .M2(m2[1]), .M3(m3[1]), .P1(p1[1]), .P2(p2[1]), .P3(p3[1]),
        .out_valid(ov[1]), .out_ready(ordy));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic void mdl_reset();
        hv.delete();
        hp.delete();
        q0.delete();
        q1.delete();
        mpos = '0;
        for (int t = 0; t < 2; t++) begin
            ec[t] = 0;
            for (int k = 0; k < 3; k++) begin
                em[t][k] = '0;
                ep[t][k] = '0;
            end
        end
    endfunction

    function automatic void mdl_accept(input int v, input bit fs);
        int    a, b, c;
        bit    hit;
        trip_t e;
        if (fs) begin
            hv.delete();
            hp.delete();
            mpos  = '0;
            ec[0] = 0;
            ec[1] = 0;
        end
        hv.push_back(v);
        hp.push_back(mpos);
        mpos = mpos + 1'b1;
        if (hv.size() > 3) begin
            void'(hv.pop_front());
            void'(hp.pop_front());
        end
        if (!fs && hv.size() == 3) begin
            a = hv[0];
            c = hv[1];
            b = hv[2];
            for (int t = 0; t < 2; t++) begin
                hit = (t == 1) ? (a < c && c >= b) : (a > c && c <= b);
                if (hit) begin
                    em[t][0] = em[t][1];
                    em[t][1] = em[t][2];
                    em[t][2] = c[W-1:0];
                    ep[t][0] = ep[t][1];
                    ep[t][1] = ep[t][2];
                    ep[t][2] = hp[1];
                    if (ec[t] < 3) ec[t]++;
                    if (ec[t] == 3) begin
                        e.m1 = em[t][0]; e.m2 = em[t][1]; e.m3 = em[t][2];
                        e.p1 = ep[t][0]; e.p2 = ep[t][1]; e.p3 = ep[t][2];
                        if (t == 1) q1.push_back(e);
                        else        q0.push_back(e);
                    end
                end
            end
        end
    endfunction

    always @(negedge clk) begin
        int    n;
        trip_t e;
        if (!rst) begin
            for (int t = 0; t < 2; t++) begin
                n = (t == 1) ? q1.size() : q0.size();
                chk($sformatf("ov%0d", t), ov[t], n != 0);
                chk($sformatf("rdy%0d", t), rdy[t], !(n != 0 && !ordy));
                if (ov[t] && ordy && n != 0) begin
                    if (t == 1) e = q1.pop_front();
                    else        e = q0.pop_front();
                    chk($sformatf("M1_%0d", t), m1[t], e.m1);
                    chk($sformatf("M2_%0d", t), m2[t], e.m2);
                    chk($sformatf("M3_%0d", t), m3[t], e.m3);
                    chk($sformatf("P1_%0d", t), p1[t], e.p1);
                    chk($sformatf("P2_%0d", t), p2[t], e.p2);
                    chk($sformatf("P3_%0d", t), p3[t], e.p3);
                end
            end
        end
    end

    task automatic send(input int v, input bit fs);
        int k;
        tv   = 1'b1;
        sin  = v[W-1:0];
        fsin = fs;
        k    = 0;
        @(negedge clk);
        while (!(rdy[0] && rdy[1]) && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (k >= 100) chk("ready_timeout", 0, 1);
        @(posedge clk);
        if (k < 100) mdl_accept(v, fs);
        #1;
        tv   = 1'b0;
        fsin = 1'b0;
    endtask

    task automatic send_seq();
        foreach (seq[i]) send(seq[i], 1'b0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        mdl_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        for (int t = 0; t < 2; t++) begin
            chk($sformatf("%s_ov%0d", tag, t), ov[t], 0);
            chk($sformatf("%s_rdy%0d", tag, t), rdy[t], 1);
            chk($sformatf("%s_M%0d", tag, t), {m1[t], m2[t], m3[t]}, 0);
            chk($sformatf("%s_P%0d", tag, t), {p1[t], p2[t], p3[t]}, 0);
        end
    endtask

    initial begin
        tv = 1'b0; fsin = 1'b0; sin = '0; ordy = 1'b1;
        total = 0; bad = 0;
        mdl_reset();
        do_reset();
        chk_zero("rst");

        // Max stream, then continuation that produces the next triple.
        seq = '{0, 5, 3, 8, 2, 9, 1};
        send_seq();
        idle(2);
        chk("t1_M1", m1[1], 5);  chk("t1_P1", p1[1], 1);
        chk("t1_M3", m3[1], 9);  chk("t1_P3", p3[1], 5);
        seq = '{4, 0};
        send_seq();
        idle(2);
        chk("t2_M1", m1[1], 8);  chk("t2_M3", m3[1], 4);
        chk("t2_P3", p3[1], 7);

        // Min stream with negative values.
        do_reset();
        seq = '{9, 2, 7, -3, 6, -8, 5};
        send_seq();
        idle(2);
        chk("t3_M1", m1[0], 2);        chk("t3_M2", m2[0], 20'hFFFFD);
        chk("t3_M3", m3[0], 20'hFFFF8); chk("t3_P3", p3[0], 5);

        // Running stream, then frame restart.
        seq = '{1, 2, 3, 4, 5, 6, 7};
        send_seq();
        send(0, 1'b1);
        seq = '{3, 1, 5, 2, 6, 0};
        send_seq();
        idle(2);
        chk("t4_M1", m1[1], 3);  chk("t4_P1", p1[1], 1);
        chk("t4_M3", m3[1], 6);  chk("t4_P3", p3[1], 5);

        // Plateau with the triple held under backpressure.
        do_reset();
        ordy = 1'b0;
        seq  = '{0, 4, 4, 1, 6, 2, 7, 0};
        send_seq();
        repeat (4) begin
            @(negedge clk);
            chk("hold_ov", ov[1], 1);   chk("hold_rdy", rdy[1], 0);
            chk("hold_M1", m1[1], 4);   chk("hold_P1", p1[1], 1);
            chk("hold_M2", m2[1], 6);   chk("hold_P2", p2[1], 4);
            chk("hold_M3", m3[1], 7);   chk("hold_P3", p3[1], 6);
        end
        @(posedge clk);
        #1 ordy = 1'b1;
        idle(2);

        // Reset mid-frame with two extrema found, then too few new extrema.
        do_reset();
        seq = '{0, 5, 3, 8, 2};
        send_seq();
        do_reset();
        chk_zero("mid");
        seq = '{0, 5, 3};
        send_seq();
        idle(5);

        chk("q_drained", q0.size() + q1.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
